// File: rtl/eth_axis_rx.sv
// eth_axis_rx: strips the 14-byte Ethernet header from an 8-bit AXI stream; define ETH_RX_DEST_FILTER_EN to drop frames not addressed to local_mac
module eth_axis_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [7:0]  m_eth_payload_axis_tdata,
  output logic        m_eth_payload_axis_tvalid,
  input  logic        m_eth_payload_axis_tready,
  output logic        m_eth_payload_axis_tlast,
  output logic        m_eth_payload_axis_tuser,
  input  logic [47:0] local_mac,
  output logic        busy,
  output logic        error_header_early_termination
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;
  state_t state, state_next;
  logic [3:0] cnt;
  logic [103:0] hsr;
  logic run, pay_rdy;
  logic [7:0] skid_data;
  logic skid_valid, skid_last, skid_user;
  logic accept, push, capture, early_end, drop_hit, out_free;

  if (DATA_WIDTH != 8 || (KEEP_ENABLE != 0 && KEEP_ENABLE != 1)) begin : g_bad_cfg
    $error("eth_axis_rx: only DATA_WIDTH = 8 is supported");
  end

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign push      = accept && state == PAYLOAD;
  assign capture   = accept && state == HEADER && cnt == 4'd13 && !s_axis_tlast;
  assign early_end = accept && (state == IDLE || state == HEADER) && s_axis_tlast && !drop_hit;
  assign out_free  = !m_eth_payload_axis_tvalid || m_eth_payload_axis_tready;

`ifdef ETH_RX_DEST_FILTER_EN
  logic [47:0] dest_early;
  assign dest_early = {hsr[39:0], s_axis_tdata};
  assign drop_hit = accept && state == HEADER && cnt == 4'd5 && !hsr[32] &&
                    dest_early != local_mac && dest_early != 48'hffff_ffff_ffff;
`else
  logic unused_local_mac;
  assign unused_local_mac = ^local_mac;
  assign drop_hit = 1'b0;
`endif

  // state register, header byte position and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      run   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= !accept ? cnt : state_next == HEADER ? cnt + 4'd1 : 4'd0;
      run   <= 1'b1;
    end

  // frame sequencing: tlast always ends the frame, byte 13 opens the payload
  always_comb
    state_next = !accept ? state :
                 s_axis_tlast ? IDLE :
                 state == IDLE ? HEADER :
                 state == HEADER ? (drop_hit ? DROP : cnt == 4'd13 ? PAYLOAD : HEADER) :
                 state;

  // input ready per state; byte 13 waits while an older header is unconsumed
  always_comb begin
    s_axis_tready = state == IDLE ? run :
                    state == HEADER ? (cnt != 4'd13 || !m_eth_hdr_valid || m_eth_hdr_ready) :
                    state == PAYLOAD ? pay_rdy : 1'b1;
    busy = state != IDLE || m_eth_payload_axis_tvalid || skid_valid;
  end

  // shift in header bytes, publish the fields on byte 13, flag short frames
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsr                            <= '0;
      m_eth_dest_mac                 <= '0;
      m_eth_src_mac                  <= '0;
      m_eth_type                     <= '0;
      m_eth_hdr_valid                <= 1'b0;
      error_header_early_termination <= 1'b0;
    end else begin
      if (accept && (state == IDLE || state == HEADER))
        hsr <= {hsr[95:0], s_axis_tdata};
      if (capture) begin
        m_eth_dest_mac <= hsr[103:56];
        m_eth_src_mac  <= hsr[55:8];
        m_eth_type     <= {hsr[7:0], s_axis_tdata};
      end
      m_eth_hdr_valid                <= capture || (m_eth_hdr_valid && !m_eth_hdr_ready);
      error_header_early_termination <= early_end;
    end

  // payload output register with one-entry skid; ready is high whenever the skid will be empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_eth_payload_axis_tdata  <= '0;
      m_eth_payload_axis_tvalid <= 1'b0;
      m_eth_payload_axis_tlast  <= 1'b0;
      m_eth_payload_axis_tuser  <= 1'b0;
      skid_data                 <= '0;
      skid_valid                <= 1'b0;
      skid_last                 <= 1'b0;
      skid_user                 <= 1'b0;
      pay_rdy                   <= 1'b0;
    end else begin
      if (out_free) begin
        m_eth_payload_axis_tvalid <= skid_valid || push;
        m_eth_payload_axis_tdata  <= skid_valid ? skid_data : s_axis_tdata;
        m_eth_payload_axis_tlast  <= skid_valid ? skid_last : s_axis_tlast;
        m_eth_payload_axis_tuser  <= skid_valid ? skid_user : s_axis_tlast && s_axis_tuser;
        skid_valid                <= 1'b0;
      end else if (push) begin
        skid_data  <= s_axis_tdata;
        skid_last  <= s_axis_tlast;
        skid_user  <= s_axis_tlast && s_axis_tuser;
        skid_valid <= 1'b1;
      end
      pay_rdy <= out_free || (!push && !skid_valid);
    end
endmodule

// File: doc/eth_axis_rx.md
Name: eth_axis_rx

Overview:
- Ethernet frame receiver: takes a raw Ethernet frame on an 8-bit AXI4-Stream and strips the 14-byte header.
- Presents dest MAC, src MAC and ethertype as a parallel header with valid/ready, and the remaining bytes as a payload AXI stream.
- Sits between the MAC RX stream and the IP/ARP demux, mirroring the TX-side framer.

Parameters:
- DATA_WIDTH, 8, stream width in bits; only 8 is supported, any other value is a simulation-time error.
- KEEP_ENABLE, 0, present for interface symmetry; with 8-bit data, tkeep is constant 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_axis_tdata  input  8  frame byte
- s_axis_tvalid  input  1  byte valid
- s_axis_tready  output  1  byte accepted when tvalid&&tready
- s_axis_tlast  input  1  last byte of frame
- s_axis_tuser  input  1  frame error flag, sampled on tlast
- m_eth_hdr_valid  output  1  header fields valid
- m_eth_hdr_ready  input  1  header consumed
- m_eth_dest_mac  output  48  first header bytes 0-5, byte 0 in bits 47:40
- m_eth_src_mac  output  48  header bytes 6-11, byte 6 in bits 47:40
- m_eth_type  output  16  header bytes 12-13, byte 12 in bits 15:8
- m_eth_payload_axis_tdata  output  8  payload byte
- m_eth_payload_axis_tvalid  output  1  payload valid
- m_eth_payload_axis_tready  input  1  payload accepted
- m_eth_payload_axis_tlast  output  1  last payload byte
- m_eth_payload_axis_tuser  output  1  copy of s_axis_tuser on last byte
- local_mac  input  48  station address, used only by the optional filter
- busy  output  1  a frame is in progress
- error_header_early_termination  output  1  one-cycle pulse

Behaviour:
- Reset (async): all outputs 0, header regs 0, state IDLE, byte counter 0. s_axis_tready rises the first clk edge after reset release.
- Reset mid-frame: abandons the frame immediately with no output pulses. After release, input bytes up to the next tlast are NOT discarded; they are parsed as a new frame.
- States:
  - IDLE: first accepted byte stores header byte 0, goes to HEADER, counter=1.
  - HEADER: each accepted byte is stored at counter position, counter+1.
  - On acceptance of byte 13 without tlast: header regs update, m_eth_hdr_valid=1 the next cycle, go to PAYLOAD.
  - PAYLOAD: bytes are forwarded to the payload stream; the accepted byte with tlast returns to IDLE.
  - DROP: accept and discard bytes until tlast, then return to IDLE.
- Header handshake:
  - m_eth_hdr_valid holds, with fields stable, until m_eth_hdr_valid&&m_eth_hdr_ready.
  - While a previous header is still pending, s_axis_tready=0 whenever the next accepted byte would be header byte 13, i.e. capture stalls.
  - A handshake in the same cycle as a new byte-13 capture is legal: valid stays 1 with the new fields.
- Payload path:
  - Registered output plus 1-entry skid buffer; latency is 1 cycle from input accept to m_eth_payload_axis_tvalid.
  - In PAYLOAD, s_axis_tready is registered: s_axis_tready = m_eth_payload_axis_tready || skid empty.
  - No beat is lost or duplicated under any tready pattern.
  - Payload may flow before the header handshake completes.
- Early termination: tlast accepted at any header byte 0..13, including a 14-byte frame with no payload, causes:
  - error_header_early_termination pulses 1 cycle after the accept;
  - no header is emitted and no payload beats are emitted;
  - return to IDLE.
- tuser: propagated only on the last payload beat. A bad frame still emits its header and payload; the consumer drops it.
- busy = state != IDLE, or payload output/skid holds data.

Optional Feature:
- Macro: ETH_RX_DEST_FILTER_EN.
- Defined: after byte 5, if dest MAC ≠ local_mac and ≠ FF:FF:FF:FF:FF:FF and the multicast bit (byte0[0]) = 0, go to DROP. No header, no payload, no error pulse.
- Not defined: local_mac is ignored and all frames pass.

Test Plan:
- 64-byte frame, dest 02:00:00:00:00:01, src 02:00:00:00:00:02, type 0x0800, payload 0x00..0x31 -> one header with exact fields, then 50 payload beats 0x00..0x31 with tlast on 0x31, tuser=0.
- 10-byte frame with tlast on byte 9 -> error pulse exactly 1 cycle wide; hdr_valid never asserts; no payload. Repeat with a 14-byte frame -> same result.
- Two back-to-back 20-byte frames with m_eth_hdr_ready held 0 for 30 cycles -> s_axis_tready stalls at frame 2 byte 13. After ready, header 1 and then header 2 emerge in order and 12 payload beats total are delivered intact.
- Random tready on payload output (50%), 200-byte frame with tuser=1 on last -> 186 beats in order, no drops, m_eth_payload_axis_tuser=1 on the last beat only.
- rst_n asserted at frame byte 30 of 60 -> all outputs 0 within the same cycle. After release, the remaining 30 bytes ending in tlast are parsed as a new frame: header from the first 14 bytes, 16 payload beats, no error pulse.
- With ETH_RX_DEST_FILTER_EN, local_mac=02:00:00:00:00:01:
  - frame to 02:00:00:00:00:09 -> nothing output;
  - frame to FF:FF:FF:FF:FF:FF -> passed;
  - frame to local_mac -> passed.
